// File: rtl/frame_stream_sequencer_pkg.sv
// Shared types and constants for the frame capture/offload sequencer.
// Imported by the sequencer top and its output buffer.
package frame_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_CAP = 2'd1,
    S_STREAM   = 2'd2
  } state_t;

  localparam logic [3:0] TKEEP_ALL  = 4'hF;
  localparam int         AXIS_WIDTH = 32;
  localparam int         OUT_DEPTH  = 2;

  // True for the beat that must carry tlast.
  function automatic logic is_last_beat(input int unsigned beat, input int unsigned length);
    return beat == length - 1;
  endfunction

endpackage

// File: rtl/frame_stream_sequencer_if.sv
// AXI-Stream port carrying one packet per captured frame to the S2MM DMA.
// The sequencer drives the master side; the DMA (or bench) the slave side.
interface frame_stream_sequencer_if;

  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);

endinterface

// File: rtl/frame_stream_sequencer_skid.sv
// Two-entry valid/ready output buffer for read-back samples.
// Exposes its occupancy so the sequencer can meter buffer reads by credit.
module frame_out_skid
  import frame_stream_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;

  assign out_valid = (occupancy != 2'd0);
  assign out_data  = head;
  assign pop       = out_valid & out_ready;

  // Head is always the presented beat; a push into a full buffer cannot
  // happen because the sequencer only reads when a slot is guaranteed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= 2'd0;
      head      <= '0;
      tail      <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) head <= push_data;
          else                   tail <= push_data;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          head      <= tail;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          if (occupancy == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/frame_stream_sequencer.sv
// Arms frame capture, waits for the buffer to fill, then streams the frame
// out as one AXI-Stream packet; repeats for a programmed count or until stop.
module frame_stream_sequencer
  import frame_stream_pkg::*;
#(
  parameter int DATA_SIZE   = 4,
  parameter int LENGTH      = 64,
  parameter int LENGTH_SIZE = 6,
  parameter int FCNT_SIZE   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [FCNT_SIZE-1:0]   frames,
  output logic                   cap_arm,
  input  logic                   cap_done,
  output logic                   rd_en,
  output logic [LENGTH_SIZE-1:0] rd_addr,
  input  logic [DATA_SIZE-1:0]   rd_data,
  frame_stream_sequencer_if.master m,
  output logic                   busy,
  output logic                   done,
  output logic [FCNT_SIZE-1:0]   frame_count,
  output logic                   overrun
);

  localparam logic [LENGTH_SIZE:0] LEN_W = (LENGTH_SIZE + 1)'(LENGTH);

  state_t                 state;
  logic [FCNT_SIZE-1:0]   frames_q;
  logic [FCNT_SIZE-1:0]   count_next;
  logic                   stop_pending;
  logic [LENGTH_SIZE:0]   issued;
  logic                   inflight;
  logic                   inflight_last;
  logic                   pop;
  logic [2:0]             pending;
  logic                   last_accept;
  logic                   skid_valid;
  logic [DATA_SIZE:0]     skid_data;
  logic [1:0]             occupancy;

  assign pop         = skid_valid & m.tready;
  assign last_accept = pop & skid_data[DATA_SIZE];
  assign pending     = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en       = (state == S_STREAM) && (issued < LEN_W) && (pending < 3'(OUT_DEPTH));
  assign rd_addr     = issued[LENGTH_SIZE-1:0];
  assign busy        = (state != S_IDLE);
  assign count_next  = frame_count + FCNT_SIZE'(1);

  assign m.tvalid = skid_valid;
  assign m.tdata  = AXIS_WIDTH'(skid_data[DATA_SIZE-1:0]);
  assign m.tlast  = skid_valid & skid_data[DATA_SIZE];
  assign m.tkeep  = TKEEP_ALL;

  // Read data arrives one cycle after the strobe; carry the last-beat tag alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && is_last_beat(32'(issued), 32'(LENGTH));
    end
  end

  frame_out_skid #(.WIDTH(DATA_SIZE + 1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, rd_data}),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .out_ready (m.tready),
    .occupancy (occupancy)
  );

  // Stop and cap_done colliding in WAIT_CAP: stop wins and the capture is dropped quietly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cap_arm      <= 1'b0;
      done         <= 1'b0;
      frame_count  <= '0;
      overrun      <= 1'b0;
      stop_pending <= 1'b0;
      frames_q     <= '0;
      issued       <= '0;
    end else begin
      done <= 1'b0;
      if (rd_en) issued <= issued + 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            frames_q     <= frames;
            frame_count  <= '0;
            overrun      <= 1'b0;
            stop_pending <= 1'b0;
            cap_arm      <= 1'b1;
            state        <= S_WAIT_CAP;
          end
          if (cap_done) overrun <= 1'b1;
        end
        S_WAIT_CAP: begin
          if (stop) begin
            cap_arm <= 1'b0;
            done    <= 1'b1;
            state   <= S_IDLE;
          end else if (cap_done) begin
            cap_arm <= 1'b0;
            issued  <= '0;
            state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (cap_done) overrun <= 1'b1;
          if (stop) stop_pending <= 1'b1;
          if (last_accept) begin
            frame_count <= count_next;
            if (stop_pending || stop || (frames_q != '0 && count_next == frames_q)) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              cap_arm <= 1'b1;
              state   <= S_WAIT_CAP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_stream_sequencer.sv
// Directed bench for frame_stream_sequencer: frame buffer model, stream monitor,
// one task per scenario with hand-computed expectations.
module tb_frame_stream_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, cap_done;
  logic [15:0] frames;
  logic        cap_arm, rd_en, busy, done, overrun;
  logic [5:0]  rd_addr;
  logic [3:0]  rd_data;
  logic [15:0] frame_count;
  logic [3:0]  mem [64];

  frame_stream_sequencer_if axis ();

  frame_stream_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .frames      (frames),
    .cap_arm     (cap_arm),
    .cap_done    (cap_done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .m           (axis),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Stream monitor, sampled on the falling edge.
  logic [31:0] beat_data [$];
  bit          beat_last [$];
  int          beat_cyc  [$];
  int          done_cnt = 0, done_cyc = 0, arm_rises = 0, proto_err = 0;
  bit          prev_stall = 0, prev_arm = 0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_arm   = 0;
    end else begin
      if (prev_stall && (!axis.tvalid || axis.tdata !== prev_data)) proto_err++;
      if (axis.tkeep !== 4'hF) proto_err++;
      if (axis.tvalid && axis.tready) begin
        beat_data.push_back(axis.tdata);
        beat_last.push_back(axis.tlast);
        beat_cyc.push_back(cyc);
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cap_arm && !prev_arm) arm_rises++;
      prev_arm = cap_arm;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    done_cnt = 0; arm_rises = 0; proto_err = 0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int g = 0;
    while (done_cnt == 0 && g < bound) begin tick(); g++; end
    vectors++;
    if (done_cnt == 0) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: no done after %0d cycles, required done", tag, bound);
    end
  endtask

  task automatic check_beats(input int nbeats, input string tag);
    int bad_data = 0, bad_last = 0;
    vectors++;
    if (beat_data.size() != nbeats) begin
      miscompares++;
      $display("[TB] FAIL %s_count: got %0d beats, required %0d", tag, beat_data.size(), nbeats);
    end
    for (int i = 0; i < beat_data.size() && i < nbeats; i++) begin
      if (beat_data[i] !== 32'(i % 16)) bad_data++;
      if (beat_last[i] !== ((i % 64) == 63)) bad_last++;
    end
    vectors++;
    if (bad_data != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_data: %0d beats with wrong tdata, required 0", tag, bad_data);
    end
    vectors++;
    if (bad_last != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_tlast: %0d beats with wrong tlast, required 0", tag, bad_last);
    end
    vectors++;
    if (proto_err != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_protocol: %0d valid/data/keep violations, required 0", tag, proto_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0; cap_done = 0; frames = '0; axis.tready = 1'b1;
    tick(); tick();
    vectors++;
    if ({busy, cap_arm, rd_en, axis.tvalid, axis.tlast, done, overrun} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b, required 0000000",
               {busy, cap_arm, rd_en, axis.tvalid, axis.tlast, done, overrun});
    end
    vectors++;
    if (axis.tdata !== 32'd0 || frame_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: tdata=%h frame_count=%0d, required 0/0", axis.tdata, frame_count);
    end
    vectors++;
    if (axis.tkeep !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL reset_tkeep: got %h, required f", axis.tkeep);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    int n;
    clear_mon(); frames = 16'd1; axis.tready = 1'b1;
    start = 1; tick(); start = 0;
    vectors++;
    if (busy !== 1'b1 || cap_arm !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_arm: busy=%b cap_arm=%b, required 1/1", busy, cap_arm);
    end
    cap_done = 1; n = cyc; tick(); cap_done = 0;
    vectors++;
    if (rd_en !== 1'b1 || rd_addr !== 6'd0 || cap_arm !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL first_read: rd_en=%b addr=%0d cap_arm=%b, required 1/0/0", rd_en, rd_addr, cap_arm);
    end
    wait_done(200, "single");
    check_beats(64, "single");
    vectors++;
    if (beat_cyc.size() == 64 && (beat_cyc[0] != n + 3 || beat_cyc[63] != n + 66)) begin
      miscompares++;
      $display("[TB] FAIL single_timing: first=%0d last=%0d, required %0d/%0d",
               beat_cyc[0], beat_cyc[63], n + 3, n + 66);
    end
    vectors++;
    if (done_cyc != n + 67 || done_cnt != 1) begin
      miscompares++;
      $display("[TB] FAIL single_done: cycle=%0d count=%0d, required %0d/1", done_cyc, done_cnt, n + 67);
    end
    vectors++;
    if (frame_count !== 16'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_count: frame_count=%0d busy=%b, required 1/0", frame_count, busy);
    end
  endtask

  task automatic test_multi_frame();
    int g = 0;
    clear_mon(); frames = 16'd3;
    start = 1; tick(); start = 0;
    while (done_cnt == 0 && g < 4000) begin
      axis.tready = 1'($urandom_range(0, 1));
      cap_done = cap_arm;
      tick(); g++;
    end
    cap_done = 0; axis.tready = 1'b1;
    vectors++;
    if (done_cnt == 0) begin
      miscompares++;
      $display("[TB] FAIL multi_timeout: no done in %0d cycles, required done", g);
    end
    tick(); tick();
    check_beats(192, "multi");
    vectors++;
    if (frame_count !== 16'd3 || done_cnt != 1 || arm_rises != 3) begin
      miscompares++;
      $display("[TB] FAIL multi_run: frame_count=%0d done=%0d arms=%0d, required 3/1/3",
               frame_count, done_cnt, arm_rises);
    end
    vectors++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL multi_idle: overrun=%b busy=%b, required 0/0", overrun, busy);
    end
  endtask

  task automatic test_stop_continuous();
    int g = 0;
    bit stopped = 0;
    clear_mon(); frames = 16'd0; axis.tready = 1'b1;
    start = 1; tick(); start = 0;
    while (done_cnt == 0 && g < 1000) begin
      cap_done = cap_arm;
      if (!stopped && beat_data.size() >= 84) begin stop = 1; stopped = 1; end
      else stop = 0;
      tick(); g++;
    end
    cap_done = 0; stop = 0;
    vectors++;
    if (done_cnt == 0) begin
      miscompares++;
      $display("[TB] FAIL stop_timeout: no done in %0d cycles, required done", g);
    end
    tick(); tick();
    check_beats(128, "stop");
    vectors++;
    if (frame_count !== 16'd2 || busy !== 1'b0 || done_cnt != 1) begin
      miscompares++;
      $display("[TB] FAIL stop_run: frame_count=%0d busy=%b done=%0d, required 2/0/1",
               frame_count, busy, done_cnt);
    end
  endtask

  task automatic test_stop_cap_and_overrun();
    int g = 0;
    clear_mon(); frames = 16'd0; axis.tready = 1'b1;
    start = 1; tick(); start = 0;
    stop = 1; cap_done = 1; tick(); stop = 0; cap_done = 0;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (busy !== 1'b0 || done_cnt != 1 || beat_data.size() != 0 || overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stop_vs_cap: busy=%b done=%0d beats=%0d overrun=%b, required 0/1/0/0",
               busy, done_cnt, beat_data.size(), overrun);
    end
    clear_mon(); frames = 16'd1;
    start = 1; tick(); start = 0;
    cap_done = 1; tick(); cap_done = 0;
    while (beat_data.size() < 10 && g < 100) begin tick(); g++; end
    cap_done = 1; tick(); cap_done = 0;
    wait_done(200, "overrun");
    check_beats(64, "overrun");
    vectors++;
    if (overrun !== 1'b1 || frame_count !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL overrun_flag: overrun=%b frame_count=%0d, required 1/1", overrun, frame_count);
    end
  endtask

  task automatic test_backpressure();
    int n, held_bad = 0;
    clear_mon(); frames = 16'd1; axis.tready = 1'b1;
    start = 1; tick(); start = 0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_clears_overrun: got %b, required 0", overrun);
    end
    cap_done = 1; n = cyc; tick(); cap_done = 0;
    while (cyc < n + 33) tick();
    axis.tready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (axis.tvalid !== 1'b1 || axis.tdata !== 32'd14) held_bad++;
      tick();
    end
    axis.tready = 1'b1;
    vectors++;
    if (held_bad != 0 || beat_data.size() != 30) begin
      miscompares++;
      $display("[TB] FAIL bp_hold: %0d bad held cycles, %0d beats before stall, required 0/30",
               held_bad, beat_data.size());
    end
    wait_done(200, "bp");
    check_beats(64, "bp");
    vectors++;
    if (beat_cyc.size() == 64 && (beat_cyc[30] != n + 43 || beat_cyc[63] != n + 76 || done_cyc != n + 77)) begin
      miscompares++;
      $display("[TB] FAIL bp_timing: beat30=%0d last=%0d done=%0d, required %0d/%0d/%0d",
               beat_cyc[30], beat_cyc[63], done_cyc, n + 43, n + 76, n + 77);
    end
  endtask

  task automatic test_reset_mid_packet();
    int g = 0, n;
    clear_mon(); frames = 16'd1; axis.tready = 1'b1;
    start = 1; tick(); start = 0;
    cap_done = 1; tick(); cap_done = 0;
    while (beat_data.size() < 20 && g < 100) begin tick(); g++; end
    rst = 1'b1; #1;
    vectors++;
    if ({busy, cap_arm, rd_en, axis.tvalid, axis.tlast, done} !== 6'b0 ||
        axis.tdata !== 32'd0 || frame_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid: ctrl=%b tdata=%h frame_count=%0d, required 000000/0/0",
               {busy, cap_arm, rd_en, axis.tvalid, axis.tlast, done}, axis.tdata, frame_count);
    end
    tick(); rst = 1'b0; tick();
    clear_mon();
    start = 1; tick(); start = 0;
    cap_done = 1; n = cyc; tick(); cap_done = 0;
    wait_done(200, "after_rst");
    check_beats(64, "after_rst");
    vectors++;
    if (beat_cyc.size() == 0 || beat_cyc[0] != n + 3) begin
      miscompares++;
      $display("[TB] FAIL after_rst_first: %0d beats, first at %0d, required first at %0d",
               beat_cyc.size(), beat_cyc.size() == 0 ? -1 : beat_cyc[0], n + 3);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 4'(i);
    test_reset();
    test_single_frame();
    test_multi_frame();
    test_stop_continuous();
    test_stop_cap_and_overrun();
    test_backpressure();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
